// File: rtl/i_dram_ctrl.sv
// Instruction-fill DRAM model: fixed-latency, 8-beat line burst from an
// internal word store that can be preloaded or rewritten through init_we.
module i_dram_ctrl #(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 12
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              DRAM_req,
   input  logic [31:0]       DRAM_req_PC,
   output logic [31:0]       DRAM_data,
   output logic              DRAM_valid,
   output logic              busy,
   input  logic              init_we,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [31:0]       init_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic [7:0]        r_lat_cnt;
   logic [2:0]        r_beat;
   logic [ADDR_W-4:0] r_line;
   logic [31:0]       r_data;
   logic              r_valid;
   logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

   logic              w_emit;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [31:0]       w_rd_data;
   logic              w_unused;

   assign w_unused   = ^{DRAM_req_PC[31:ADDR_W], DRAM_req_PC[2:0]};
   assign w_rd_addr  = {r_line, r_beat};
   assign w_rd_data  = r_mem[w_rd_addr];
   assign DRAM_data  = r_data;
   assign DRAM_valid = r_valid;
   assign busy       = (r_state != ST_IDLE);

   // A beat goes out on the last WAIT edge (beat 0) and every BURST edge.
   always_comb begin
      w_emit = 1'b0;
      case (r_state)
         ST_WAIT:  w_emit = (r_lat_cnt == 8'd0);
         ST_BURST: w_emit = 1'b1;
         default:  w_emit = 1'b0;
      endcase
   end

   // Backing store: no reset so contents survive RESET; writes allowed always.
   always_ff @(posedge CLK) begin
      if (init_we) begin
         r_mem[init_addr] <= init_data;
      end
   end

   // Fill sequencer and registered beat outputs; data reads see pre-write contents.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state   <= ST_IDLE;
         r_lat_cnt <= 8'd0;
         r_beat    <= 3'd0;
         r_line    <= '0;
         r_valid   <= 1'b0;
         r_data    <= 32'd0;
      end else begin
         r_valid <= w_emit;
         r_data  <= w_emit ? w_rd_data : 32'd0;
         case (r_state)
            ST_IDLE: begin
               if (DRAM_req) begin
                  r_line    <= DRAM_req_PC[ADDR_W-1:3];
                  r_lat_cnt <= 8'(LATENCY - 1);
                  r_beat    <= 3'd0;
                  r_state   <= ST_WAIT;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (r_lat_cnt == 8'd0) begin
                  r_beat  <= 3'd1;
                  r_state <= ST_BURST;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 8'd1;
               end
            end
            ST_BURST: begin
               if (r_beat == 3'd7) begin
                  r_beat  <= 3'd0;
                  r_state <= ST_DONE;
               end else begin
                  r_beat <= r_beat + 3'd1;
               end
            end
            ST_DONE: begin
               if (!DRAM_req) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i_dram_ctrl.sv
// Directed bench for i_dram_ctrl: one instance at LATENCY=4, one at LATENCY=1.
module tb_i_dram_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        req0, req1;
   logic [31:0] pc0, pc1;
   logic        init_we;
   logic [11:0] init_addr;
   logic [31:0] init_data;
   logic [31:0] d0_data, d1_data;
   logic        d0_valid, d1_valid, d0_busy, d1_busy;

   logic [31:0] exp_mem [0:4095];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   i_dram_ctrl #(.LATENCY(4), .ADDR_W(12)) dut0 (
      .CLK(CLK), .RESET(RESET), .DRAM_req(req0), .DRAM_req_PC(pc0),
      .DRAM_data(d0_data), .DRAM_valid(d0_valid), .busy(d0_busy),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

   i_dram_ctrl #(.LATENCY(1), .ADDR_W(12)) dut1 (
      .CLK(CLK), .RESET(RESET), .DRAM_req(req1), .DRAM_req_PC(pc1),
      .DRAM_data(d1_data), .DRAM_valid(d1_valid), .busy(d1_busy),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Whole fill on one instance: sample edge, latency, 8 beats, DONE hold, release.
   task automatic fill(input int sel, input int lat, input logic [31:0] pc, input string tag);
      logic [11:0] base;
      base = {pc[11:3], 3'b000};
      if (sel == 0) begin req0 = 1'b1; pc0 = pc; end
      else          begin req1 = 1'b1; pc1 = pc; end
      tick();
      chk({tag, "_sample_valid"}, (sel == 0) ? d0_valid : d1_valid, 32'd0);
      chk({tag, "_sample_busy"},  (sel == 0) ? d0_busy  : d1_busy,  32'd1);
      for (int i = 1; i < lat; i++) begin
         tick();
         chk({tag, "_wait_valid"}, (sel == 0) ? d0_valid : d1_valid, 32'd0);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         chk({tag, "_beat_valid"}, (sel == 0) ? d0_valid : d1_valid, 32'd1);
         chk({tag, "_beat_data"},  (sel == 0) ? d0_data  : d1_data,  exp_mem[base + 12'(k)]);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         chk({tag, "_done_valid"}, (sel == 0) ? d0_valid : d1_valid, 32'd0);
         chk({tag, "_done_data"},  (sel == 0) ? d0_data  : d1_data,  32'd0);
         chk({tag, "_done_busy"},  (sel == 0) ? d0_busy  : d1_busy,  32'd1);
      end
      if (sel == 0) req0 = 1'b0; else req1 = 1'b0;
      tick();
      chk({tag, "_idle_busy"}, (sel == 0) ? d0_busy : d1_busy, 32'd0);
   endtask

   initial begin
      RESET = 1'b0; req0 = 1'b0; req1 = 1'b0; pc0 = 32'd0; pc1 = 32'd0;
      init_we = 1'b0; init_addr = 12'd0; init_data = 32'd0;
      // Preload under reset: store writes must still land.
      for (int k = 0; k < 64; k++) begin
         init_we = 1'b1; init_addr = 12'(k); init_data = 32'h1000 + 32'(k);
         exp_mem[k] = 32'h1000 + 32'(k);
         tick();
      end
      init_we = 1'b0;
      tick();
      chk("rst_valid", d0_valid, 32'd0);
      chk("rst_data",  d0_data,  32'd0);
      chk("rst_busy",  d0_busy,  32'd0);
      RESET = 1'b1;
      tick();
      chk("post_rst_busy", d0_busy, 32'd0);

      fill(0, 4, 32'h0000_0010, "basic");
      fill(0, 4, 32'h0000_0020, "second");
      fill(0, 4, 32'h0000_0015, "misalign");
      fill(0, 4, 32'hFFFF_F010, "highbits");

      // Request dropped during WAIT: burst still completes, then straight to IDLE.
      req0 = 1'b1; pc0 = 32'h0000_0008;
      tick();
      tick();
      req0 = 1'b0;
      tick(); tick();
      chk("drop_wait_valid", d0_valid, 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("drop_beat_valid", d0_valid, 32'd1);
         chk("drop_beat_data",  d0_data,  32'h1008 + 32'(k));
      end
      tick();
      chk("drop_end_valid", d0_valid, 32'd0);
      chk("drop_end_busy",  d0_busy,  32'd0);

      // Reset in the middle of a burst, request held across it.
      req0 = 1'b1; pc0 = 32'h0000_0018;
      tick(); tick(); tick(); tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mid_beat_data", d0_data, 32'h1018 + 32'(k));
      end
      RESET = 1'b0;
      tick();
      chk("mid_rst_valid", d0_valid, 32'd0);
      chk("mid_rst_data",  d0_data,  32'd0);
      chk("mid_rst_busy",  d0_busy,  32'd0);
      tick();
      chk("rst_ignores_req", d0_busy, 32'd0);
      RESET = 1'b1;
      fill(0, 4, 32'h0000_0018, "after_rst");

      // Store write aimed at the word read for beat 2: old data, then new on refill.
      req0 = 1'b1; pc0 = 32'h0000_0010;
      tick(); tick(); tick(); tick();
      tick();
      chk("rbw_beat0", d0_data, 32'h1010);
      tick();
      chk("rbw_beat1", d0_data, 32'h1011);
      init_we = 1'b1; init_addr = 12'h012; init_data = 32'h0000_DEAD;
      tick();
      init_we = 1'b0;
      exp_mem[12'h012] = 32'h0000_DEAD;
      chk("rbw_beat2_old", d0_data, 32'h1012);
      for (int k = 3; k < 8; k++) begin
         tick();
         chk("rbw_beat_rest", d0_data, 32'h1010 + 32'(k));
      end
      req0 = 1'b0;
      tick();
      chk("rbw_idle", d0_busy, 32'd0);
      fill(0, 4, 32'h0000_0010, "rbw_new");
      chk("model_dead", exp_mem[12'h012], 32'h0000_DEAD);

      fill(1, 1, 32'h0000_0028, "lat1");
      fill(1, 1, 32'h0000_0010, "lat1_dead");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
